// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - register file write-port arbiter between WB and long-latency results
// FIFO drains into idle WB slots, a starvation guard steals slots, and a busy scoreboard flags hazards.
module rf_write_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        lu_valid,
    input  logic [4:0]  lu_addr,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    input  logic        iss_en,
    input  logic [4:0]  iss_addr,
    input  logic [4:0]  rd_addr1,
    input  logic [4:0]  rd_addr2,
    output logic        hazard1,
    output logic        hazard2,
    output logic        pipe_stall,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL  = (AW+1)'(DEPTH);
    localparam logic [3:0]  SCNT_LIM  = 4'(STARVE_LIMIT);

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [3:0]    scnt_q, scnt_d;
    logic [31:0]   busy_q, busy_d;
    logic [4:0]    fifo_addr_q [DEPTH];
    logic [4:0]    fifo_addr_d [DEPTH];
    logic [31:0]   fifo_data_q [DEPTH];
    logic [31:0]   fifo_data_d [DEPTH];

    logic          nonempty;
    logic          not_full;
    logic          accept;
    logic          starve;
    logic          head_grant;
    logic          wb_grant;
    logic [4:0]    head_addr;
    logic [31:0]   head_data;
    logic [4:0]    sel_addr;
    logic [31:0]   sel_data;

    always_comb begin
        nonempty   = (cnt_q != '0);
        not_full   = (cnt_q != CNT_FULL);
        accept     = lu_valid && not_full;
        head_addr  = fifo_addr_q[rd_ptr_q];
        head_data  = fifo_data_q[rd_ptr_q];
        starve     = nonempty && (scnt_q >= SCNT_LIM);
        head_grant = starve || (!wb_en && nonempty);
        wb_grant   = !starve && wb_en;
        sel_addr   = 5'd0;
        sel_data   = 32'd0;
        if (head_grant) begin
            sel_addr = head_addr;
            sel_data = head_data;
        end else if (wb_grant) begin
            sel_addr = wb_addr;
            sel_data = wb_data;
        end
    end

    // Outputs are gated by rstn so nothing leaks out while reset is held.
    always_comb begin
        lu_ready   = rstn && not_full;
        pipe_stall = rstn && starve;
        rf_we      = rstn && (head_grant || wb_grant) && (sel_addr != 5'd0);
        rf_waddr   = rstn ? sel_addr : 5'd0;
        rf_wdata   = rstn ? sel_data : 32'd0;
        hazard1    = rstn && (rd_addr1 != 5'd0) && busy_q[rd_addr1];
        hazard2    = rstn && (rd_addr2 != 5'd0) && busy_q[rd_addr2];
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            fifo_addr_d[i] = fifo_addr_q[i];
            fifo_data_d[i] = fifo_data_q[i];
        end
        if (accept) begin
            fifo_addr_d[wr_ptr_q] = lu_addr;
            fifo_data_d[wr_ptr_q] = lu_data;
        end
        wr_ptr_d = wr_ptr_q + AW'(accept);
        rd_ptr_d = rd_ptr_q + AW'(head_grant);
        cnt_d    = cnt_q + (AW+1)'(accept) - (AW+1)'(head_grant);

        scnt_d = scnt_q;
        if (head_grant || !nonempty) begin
            scnt_d = 4'd0;
        end else if (scnt_q != 4'hF) begin
            scnt_d = scnt_q + 4'd1;
        end

        // Clear before set so a same-cycle reservation of the popped register wins.
        busy_d = busy_q;
        if (head_grant) begin
            busy_d[head_addr] = 1'b0;
        end
        if (iss_en && (iss_addr != 5'd0)) begin
            busy_d[iss_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            scnt_q   <= 4'd0;
            busy_q   <= 32'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            scnt_q   <= scnt_d;
            busy_q   <= busy_d;
        end
    end

    // Entry storage needs no reset; the count alone decides what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            fifo_addr_q[i] <= fifo_addr_d[i];
            fifo_data_q[i] <= fifo_data_d[i];
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - bench for rf_write_arbiter
// Directed vector table plus randomized traffic against a queue-based reference model.
module tb_rf_write_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk;
    logic        rstn;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        lu_valid;
    logic [4:0]  lu_addr;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic        hazard1;
    logic        hazard2;
    logic        pipe_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rstn(rstn),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .lu_valid(lu_valid), .lu_addr(lu_addr), .lu_data(lu_data), .lu_ready(lu_ready),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .hazard1(hazard1), .hazard2(hazard2),
        .pipe_stall(pipe_stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rstn;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        lu_valid;
        logic [4:0]  lu_addr;
        logic [31:0] lu_data;
        logic        iss_en;
        logic [4:0]  iss_addr;
        logic [4:0]  rd1;
        logic [4:0]  rd2;
        logic        e_ready;
        logic        e_h1;
        logic        e_h2;
        logic        e_stall;
        logic        e_we;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
    } vec_t;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    int          tests = 0;
    int          fails = 0;
    ent_t        mq[$];
    int          scnt_m = 0;
    logic [31:0] busy_m = 32'd0;
    vec_t        tbl[$];

    function automatic vec_t mk(
        input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
        input logic lv, input logic [4:0] la, input logic [31:0] ld,
        input logic ie, input logic [4:0] ia, input logic [4:0] r1, input logic [4:0] r2,
        input logic erdy, input logic eh1, input logic eh2, input logic est,
        input logic ewe, input logic [4:0] ewa, input logic [31:0] ewd);
        vec_t v;
        v.rstn = r; v.wb_en = we; v.wb_addr = wa; v.wb_data = wd;
        v.lu_valid = lv; v.lu_addr = la; v.lu_data = ld;
        v.iss_en = ie; v.iss_addr = ia; v.rd1 = r1; v.rd2 = r2;
        v.e_ready = erdy; v.e_h1 = eh1; v.e_h2 = eh2; v.e_stall = est;
        v.e_we = ewe; v.e_waddr = ewa; v.e_wdata = ewd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input bit use_tbl, input string tag);
        logic        ne, starve, head_win, wb_win;
        logic        m_we, m_rdy, m_h1, m_h2, m_st;
        logic [4:0]  m_wa;
        logic [31:0] m_wd;
        rstn = v.rstn; wb_en = v.wb_en; wb_addr = v.wb_addr; wb_data = v.wb_data;
        lu_valid = v.lu_valid; lu_addr = v.lu_addr; lu_data = v.lu_data;
        iss_en = v.iss_en; iss_addr = v.iss_addr; rd_addr1 = v.rd1; rd_addr2 = v.rd2;
        #2;
        ne       = (mq.size() != 0);
        starve   = ne && (scnt_m >= LIMIT);
        head_win = v.rstn && (starve || (!v.wb_en && ne));
        wb_win   = v.rstn && !starve && v.wb_en;
        m_wa = 5'd0; m_wd = 32'd0;
        if (head_win) begin
            m_wa = mq[0].a; m_wd = mq[0].d;
        end else if (wb_win) begin
            m_wa = v.wb_addr; m_wd = v.wb_data;
        end
        m_we  = (head_win || wb_win) && (m_wa != 5'd0);
        m_rdy = v.rstn && (mq.size() < DEPTH);
        m_st  = v.rstn && starve;
        m_h1  = v.rstn && (v.rd1 != 5'd0) && busy_m[v.rd1];
        m_h2  = v.rstn && (v.rd2 != 5'd0) && busy_m[v.rd2];
        if (v.rstn && v.iss_en && v.iss_addr != 5'd0 && busy_m[v.iss_addr]) begin
            fails++;
            $display("FAIL %s contract: issue to busy r%0d", tag, v.iss_addr);
        end
        if (v.rstn && v.wb_en && !starve && v.wb_addr != 5'd0 && busy_m[v.wb_addr]) begin
            fails++;
            $display("FAIL %s contract: wb to busy r%0d", tag, v.wb_addr);
        end
        chk({tag, " ready"}, 32'(lu_ready), 32'(m_rdy));
        chk({tag, " hazard1"}, 32'(hazard1), 32'(m_h1));
        chk({tag, " hazard2"}, 32'(hazard2), 32'(m_h2));
        chk({tag, " stall"}, 32'(pipe_stall), 32'(m_st));
        chk({tag, " we"}, 32'(rf_we), 32'(m_we));
        if (m_we || !v.rstn) begin
            chk({tag, " waddr"}, 32'(rf_waddr), 32'(m_wa));
            chk({tag, " wdata"}, rf_wdata, m_wd);
        end
        if (use_tbl) begin
            chk({tag, " tbl ready"}, 32'(lu_ready), 32'(v.e_ready));
            chk({tag, " tbl hazard1"}, 32'(hazard1), 32'(v.e_h1));
            chk({tag, " tbl hazard2"}, 32'(hazard2), 32'(v.e_h2));
            chk({tag, " tbl stall"}, 32'(pipe_stall), 32'(v.e_stall));
            chk({tag, " tbl we"}, 32'(rf_we), 32'(v.e_we));
            if (v.e_we || !v.rstn) begin
                chk({tag, " tbl waddr"}, 32'(rf_waddr), 32'(v.e_waddr));
                chk({tag, " tbl wdata"}, rf_wdata, v.e_wdata);
            end
        end
        @(posedge clk);
        if (!v.rstn) begin
            mq.delete();
            scnt_m = 0;
            busy_m = 32'd0;
        end else begin
            if (head_win) begin
                busy_m[mq[0].a] = 1'b0;
                void'(mq.pop_front());
            end
            if (v.lu_valid && m_rdy) begin
                mq.push_back({v.lu_addr, v.lu_data});
            end
            if (head_win || !ne) scnt_m = 0;
            else if (scnt_m < 15) scnt_m = scnt_m + 1;
            if (v.iss_en && v.iss_addr != 5'd0) busy_m[v.iss_addr] = 1'b1;
            busy_m[0] = 1'b0;
        end
        #1;
    endtask

    function automatic logic [4:0] pick_free();
        logic [4:0] a;
        for (int t = 0; t < 64; t++) begin
            a = 5'($urandom_range(0, 31));
            if (!busy_m[a]) return a;
        end
        return 5'd0;
    endfunction

    initial begin
        vec_t v;
        // reset
        tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0, 0,0,   0,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0, 0,0,   0,0,0,0,0,0,0));
        // idle drain
        tbl.push_back(mk(1,0,0,0, 0,0,0, 1,5, 5,0,   1,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0, 1,5,32'hDEADBEEF, 0,0, 5,0, 1,1,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0, 0,0,0, 0,0, 5,0,   1,1,0,0,1,5,32'hDEADBEEF));
        tbl.push_back(mk(1,0,0,0, 0,0,0, 0,0, 5,0,   1,0,0,0,0,0,0));
        // register zero
        tbl.push_back(mk(1,0,0,0, 1,0,32'h11, 1,0, 0,0, 1,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0, 0,0,0, 0,0, 0,0,   1,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0, 0,0,0, 0,0, 0,5,   1,0,0,0,0,0,0));
        // simultaneous set/clear of r9
        tbl.push_back(mk(1,0,0,0, 1,9,32'h99, 0,0, 0,0, 1,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0, 0,0,0, 1,9, 9,0,   1,0,0,0,1,9,32'h99));
        tbl.push_back(mk(1,0,0,0, 0,0,0, 0,0, 9,0,   1,1,0,0,0,0,0));
        // FIFO full with WB busy
        tbl.push_back(mk(1,1,3,32'h33, 1,10,32'hA, 0,0, 9,0, 1,1,0,0,1,3,32'h33));
        tbl.push_back(mk(1,1,3,32'h34, 1,11,32'hB, 0,0, 9,0, 1,1,0,0,1,3,32'h34));
        tbl.push_back(mk(1,1,3,32'h35, 1,12,32'hC, 0,0, 9,0, 0,1,0,0,1,3,32'h35));
        tbl.push_back(mk(1,0,0,0, 1,12,32'hC, 0,0, 9,0, 0,1,0,0,1,10,32'hA));
        tbl.push_back(mk(1,0,0,0, 1,12,32'hC, 0,0, 9,0, 1,1,0,0,1,11,32'hB));
        tbl.push_back(mk(1,0,0,0, 0,0,0, 0,0, 9,0,   1,1,0,0,1,12,32'hC));
        tbl.push_back(mk(1,0,0,0, 0,0,0, 0,0, 9,0,   1,1,0,0,0,0,0));
        // starvation: four WB writes, then the head steals the slot
        tbl.push_back(mk(1,1,4,32'h40, 1,7,32'h77, 0,0, 0,0, 1,0,0,0,1,4,32'h40));
        tbl.push_back(mk(1,1,4,32'h41, 0,0,0, 0,0, 0,0, 1,0,0,0,1,4,32'h41));
        tbl.push_back(mk(1,1,4,32'h42, 0,0,0, 0,0, 0,0, 1,0,0,0,1,4,32'h42));
        tbl.push_back(mk(1,1,4,32'h43, 0,0,0, 0,0, 0,0, 1,0,0,0,1,4,32'h43));
        tbl.push_back(mk(1,1,4,32'h44, 0,0,0, 0,0, 0,0, 1,0,0,0,1,4,32'h44));
        tbl.push_back(mk(1,1,4,32'h45, 0,0,0, 0,0, 0,0, 1,0,0,1,1,7,32'h77));
        tbl.push_back(mk(1,1,4,32'h45, 0,0,0, 0,0, 0,0, 1,0,0,0,1,4,32'h45));
        // reset mid-operation
        tbl.push_back(mk(1,1,2,32'h20, 1,13,32'hD, 1,13, 0,0, 1,0,0,0,1,2,32'h20));
        tbl.push_back(mk(1,1,2,32'h21, 1,14,32'hE, 1,14, 13,14, 1,1,0,0,1,2,32'h21));
        tbl.push_back(mk(0,1,2,32'h21, 0,0,0, 0,0, 13,14, 0,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0, 0,0,0, 0,0, 13,14, 1,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0, 0,0,0, 0,0, 13,14, 1,0,0,0,0,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], 1'b1, $sformatf("row%0d", i));
        end

        for (int n = 0; n < 3000; n++) begin
            v = mk(1,0,0,0, 0,0,0, 0,0, 0,0, 0,0,0,0,0,0,0);
            v.rstn     = ($urandom_range(0, 299) != 0);
            v.wb_en    = 1'($urandom_range(0, 1));
            v.wb_addr  = pick_free();
            v.wb_data  = $urandom();
            v.lu_valid = 1'($urandom_range(0, 1));
            v.lu_addr  = 5'($urandom_range(0, 31));
            v.lu_data  = $urandom();
            v.iss_en   = ($urandom_range(0, 3) == 0);
            v.iss_addr = pick_free();
            v.rd1      = 5'($urandom_range(0, 31));
            v.rd2      = 5'($urandom_range(0, 31));
            step(v, 1'b0, $sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
